sram_avalon_slave: RTL and testbench

//  Avalon-MM slave (responder) for the BeMicro 256Kx16 async SRAM, bridging Qsys master transactions onto SRAM pins.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_dq_io.sv | 37 +++
 rtl/sram_avalon_slave.sv | 183 ++++++++++++++++++
 tb/tb_sram_avalon_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the Avalon-MM to async SRAM bridge.
package sram_pkg;

  localparam int unsigned SRAM_MIN_RD_CYCLES = 1;
  localparam int unsigned SRAM_MIN_WR_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } sram_state_t;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Bidirectional SRAM data pin: registered write driver and read capture register.
module sram_dq_io #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic                  drive,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  inout  wire  [DATA_WIDTH-1:0] dq
);

  logic [DATA_WIDTH-1:0] dq_out;
  logic                  dq_en;

  // Write data is held in dq_out for the whole write so it stays stable across the WE pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dq_out <= '0;
      dq_en  <= 1'b0;
      rdata  <= '0;
    end else begin
      dq_en <= drive;
      if (load) begin
        dq_out <= wdata;
      end
      if (capture) begin
        rdata <= dq;
      end
    end
  end

  assign dq = dq_en ? dq_out : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sram_avalon_slave.sv
// Avalon-MM slave bridging single, non-pipelined transfers onto a 256Kx16 async SRAM.
module sram_avalon_slave
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_CYCLES  = 1,
  parameter int unsigned WR_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_waitrequest,
  output logic                    sram_csN,
  output logic                    sram_cs,
  output logic                    sram_oeN,
  output logic                    sram_weN,
  output logic [DATA_WIDTH/8-1:0] sram_beN,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  inout  wire  [DATA_WIDTH-1:0]   sram_dq
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned RD_CYC   = (RD_CYCLES < SRAM_MIN_RD_CYCLES) ? SRAM_MIN_RD_CYCLES : RD_CYCLES;
  localparam int unsigned WR_CYC   = (WR_CYCLES < SRAM_MIN_WR_CYCLES) ? SRAM_MIN_WR_CYCLES : WR_CYCLES;
  localparam int unsigned MAX_CYC  = max_cycles(RD_CYC, WR_CYC);
  localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sram_state_t           state;
  sram_state_t           next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic                  accept_wr;
  logic                  accept_rd;
  logic                  capture;
  logic                  cs_next;
  logic                  oe_next;
  logic                  we_next;
  logic                  wait_next;
  logic                  drive_next;
  logic [BE_WIDTH-1:0]   be_n_next;

  // Next-state decode; SRAM pin levels are derived from the state being entered so they register with it.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    cs_next    = 1'b0;
    oe_next    = 1'b0;
    we_next    = 1'b0;
    wait_next  = 1'b1;
    drive_next = 1'b0;
    be_n_next  = sram_beN;
    accept_wr  = (state == IDLE) && avs_write;
    accept_rd  = (state == IDLE) && avs_read && !avs_write;

    case (state)
      IDLE: begin
        if (avs_write) begin
          next_state = WR_SETUP;
        end else if (avs_read) begin
          next_state = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        if (cnt >= RD_LAST) begin
          next_state = RD_DONE;
          capture    = 1'b1;
        end
      end
      RD_DONE:  next_state = IDLE;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: begin
        if (cnt >= WR_LAST) begin
          next_state = WR_HOLD;
        end
      end
      WR_HOLD:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    case (next_state)
      RD_ACCESS: begin
        cs_next = 1'b1;
        oe_next = 1'b1;
      end
      RD_DONE: begin
        cs_next   = 1'b1;
        oe_next   = 1'b1;
        wait_next = 1'b0;
      end
      WR_SETUP: begin
        cs_next    = 1'b1;
        drive_next = 1'b1;
      end
      WR_PULSE: begin
        cs_next    = 1'b1;
        drive_next = 1'b1;
        we_next    = 1'b1;
      end
      WR_HOLD: begin
        cs_next    = 1'b1;
        drive_next = 1'b1;
        wait_next  = 1'b0;
      end
      default: begin
        cs_next = 1'b0;
      end
    endcase

    if (accept_wr) begin
      be_n_next = ~avs_byteenable;
    end else if (accept_rd) begin
      be_n_next = '0;
    end else if (next_state == IDLE) begin
      be_n_next = '1;
    end

    // Phase counter restarts on every state change and saturates rather than wrapping.
    if (next_state != state) begin
      next_cnt = '0;
    end else if (cnt == CNT_MAX) begin
      next_cnt = cnt;
    end else begin
      next_cnt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Registered pin drivers; sram_addr doubles as the address holding register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sram_csN        <= 1'b1;
      sram_cs         <= 1'b0;
      sram_oeN        <= 1'b1;
      sram_weN        <= 1'b1;
      sram_beN        <= '1;
      sram_addr       <= '0;
      avs_waitrequest <= 1'b1;
    end else begin
      sram_csN        <= ~cs_next;
      sram_cs         <= cs_next;
      sram_oeN        <= ~oe_next;
      sram_weN        <= ~we_next;
      sram_beN        <= be_n_next;
      avs_waitrequest <= wait_next;
      if (accept_wr || accept_rd) begin
        sram_addr <= avs_address;
      end
    end
  end

  sram_dq_io #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dq_io (
    .clk     (clk),
    .rstN    (rstN),
    .load    (accept_wr),
    .drive   (drive_next),
    .capture (capture),
    .wdata   (avs_writedata),
    .rdata   (avs_readdata),
    .dq      (sram_dq)
  );

endmodule

// File: tb/tb_sram_avalon_slave.sv
// Bench: Avalon master BFM with scoreboard against a behavioural async SRAM, plus a default-timing instance.
module tb_sram_avalon_slave;

  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 16;
  localparam int unsigned BW    = 2;
  localparam int unsigned RD    = 3;
  localparam int unsigned WR    = 2;
  localparam int          BOUND = 64;
  localparam logic [DW-1:0] ZZ  = {DW{1'bz}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [BW-1:0] avs_byteenable;
  logic [DW-1:0] avs_writedata;
  logic [DW-1:0] avs_readdata;
  logic          avs_waitrequest;
  logic          sram_csN;
  logic          sram_cs;
  logic          sram_oeN;
  logic          sram_weN;
  logic [BW-1:0] sram_beN;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;

  sram_avalon_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_CYCLES  (RD),
    .WR_CYCLES  (WR)
  ) dut (
    .clk             (clk),
    .rstN            (rstN),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_byteenable  (avs_byteenable),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .sram_csN        (sram_csN),
    .sram_cs         (sram_cs),
    .sram_oeN        (sram_oeN),
    .sram_weN        (sram_weN),
    .sram_beN        (sram_beN),
    .sram_addr       (sram_addr),
    .sram_dq         (sram_dq)
  );

  // Default-timing instance with a fixed-pattern responder on its data bus.
  logic [AW-1:0] d_address;
  logic          d_read;
  logic          d_write;
  logic [DW-1:0] d_readdata;
  logic          d_waitrequest;
  logic          d_csN;
  logic          d_cs;
  logic          d_oeN;
  logic          d_weN;
  logic [BW-1:0] d_beN;
  logic [AW-1:0] d_addr;
  wire  [DW-1:0] d_dq;

  sram_avalon_slave dut_def (
    .clk             (clk),
    .rstN            (rstN),
    .avs_address     (d_address),
    .avs_read        (d_read),
    .avs_write       (d_write),
    .avs_byteenable  (2'b11),
    .avs_writedata   (16'h0F0F),
    .avs_readdata    (d_readdata),
    .avs_waitrequest (d_waitrequest),
    .sram_csN        (d_csN),
    .sram_cs         (d_cs),
    .sram_oeN        (d_oeN),
    .sram_weN        (d_weN),
    .sram_beN        (d_beN),
    .sram_addr       (d_addr),
    .sram_dq         (d_dq)
  );

  assign d_dq = (d_oeN === 1'b0 && d_csN === 1'b0) ? 16'hC3A5 : ZZ;

  // Behavioural async SRAM: drives on CS&OE, latches byte lanes on the rising edge of WE.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit   [DW-1:0] ref_mem [0:(1<<AW)-1];

  assign sram_dq = (sram_csN === 1'b0 && sram_oeN === 1'b0 && sram_weN === 1'b1) ? mem[sram_addr] : ZZ;

  always @(posedge sram_weN) begin
    if (sram_csN === 1'b0) begin
      for (int b = 0; b < BW; b++) begin
        if (!sram_beN[b]) mem[sram_addr][8*b +: 8] = sram_dq[8*b +: 8];
      end
    end
  end

  int overlap = 0;
  always @(negedge clk) begin
    if (sram_oeN === 1'b0 && sram_weN === 1'b0) overlap++;
    if (d_oeN === 1'b0 && d_weN === 1'b0) overlap++;
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];
  int last_we_low;
  int last_oe_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One Avalon transfer; lat is the cycle (request cycle = 0) in which waitrequest is seen low.
  task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be, output int lat);
    logic [DW-1:0] exp;
    avs_address    = a;
    avs_read       = rd;
    avs_write      = wr;
    avs_byteenable = be;
    avs_writedata  = d;
    lat            = 0;
    last_we_low    = 0;
    last_oe_low    = 0;
    @(negedge clk);
    while (avs_waitrequest !== 1'b0 && lat < BOUND) begin
      if (sram_weN === 1'b0) last_we_low++;
      if (sram_oeN === 1'b0) last_oe_low++;
      lat++;
      @(negedge clk);
    end
    if (sram_oeN === 1'b0) last_oe_low++;
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      check("rdata", avs_readdata, exp);
    end
    @(posedge clk);
    #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be, input logic also_rd);
    int lat;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    xfer(also_rd, 1'b1, a, d, be, lat);
    check("wr_lat", lat, WR + 2);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int lat;
    exp_q.push_back(ref_mem[a]);
    xfer(1'b1, 1'b0, a, '0, '0, lat);
    check("rd_lat", lat, RD + 1);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {sram_csN, sram_cs, sram_oeN, sram_weN, avs_waitrequest}, 5'b10111);
    check({tag, "_dq"}, sram_dq, ZZ);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int we_low;
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rstN = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = '0; avs_writedata = '0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0;

    #12;
    check_idle("rst_ctrl");
    check("rst_be", sram_beN, 2'b11);
    check("rst_addr", sram_addr, 0);
    check("rst_rdata", avs_readdata, 0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
    end
    @(posedge clk);
    #1;

    do_write(18'h00010, 16'h1234, 2'b11, 1'b0);
    check("wr_we_width", last_we_low, WR);
    do_read(18'h00010);
    check("rd_oe_width", last_oe_low, RD + 1);
    do_write(18'h00010, 16'hAB00, 2'b10, 1'b0);
    do_read(18'h00010);
    do_write(18'h00010, 16'h5555, 2'b00, 1'b0);
    do_read(18'h00010);
    do_write(18'h3FFFF, 16'hFFFF, 2'b11, 1'b1);
    do_read(18'h3FFFF);

    // Abort a write with reset while WE is low.
    avs_address = 18'h2AAAA; avs_writedata = 16'h7777;
    avs_byteenable = 2'b11; avs_write = 1'b1;
    lat = 0;
    @(negedge clk);
    while (sram_weN !== 1'b0 && lat < BOUND) begin
      lat++;
      @(negedge clk);
    end
    check("abort_reach_pulse", lat, 2);
    #1;
    rstN = 1'b0;
    #1;
    check_idle("abort");
    avs_write = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check_idle("post_abort");
    @(posedge clk);
    #1;
    do_read(18'h00010);

    for (int i = 0; i < 100; i++) begin
      a = 18'h00100 + AW'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0, 1:    do_read(a);
        2:       do_write(a, DW'($urandom), BW'($urandom_range(0, 3)), 1'b0);
        default: do_write(a, DW'($urandom), BW'($urandom_range(0, 3)), 1'b1);
      endcase
    end
    check("oe_we_overlap", overlap, 0);

    // Default timing: read completes in cycle 2, write in cycle 3 with a one-cycle WE pulse.
    d_address = 18'h00005;
    d_read = 1'b1;
    lat = 0;
    @(negedge clk);
    while (d_waitrequest !== 1'b0 && lat < BOUND) begin
      lat++;
      @(negedge clk);
    end
    check("def_rd_lat", lat, 2);
    check("def_rdata", d_readdata, 16'hC3A5);
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_write = 1'b1;
    lat = 0;
    we_low = 0;
    @(negedge clk);
    while (d_waitrequest !== 1'b0 && lat < BOUND) begin
      if (d_weN === 1'b0) we_low++;
      lat++;
      @(negedge clk);
    end
    check("def_wr_lat", lat, 3);
    check("def_we_width", we_low, 1);
    @(posedge clk);
    #1;
    d_write = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
